// File: rtl/serpent_pipe_sched_if.sv
// -----------------------------------------------------------------------------
// serpent_pipe_sched_if
//
// Bundles the requester-side and response-side handshakes of the Serpent
// pipeline scheduler.
//
//   req_valid [NREQ]       per-requester block valid
//   req_data  [NREQ*128]   per-requester plaintext, requester i in [128*i +: 128]
//   req_ready [NREQ]       one-hot (or zero) accept strobe
//   rsp_valid              response FIFO not empty
//   rsp_ready              consumer accept
//   rsp_data  [128]        ciphertext at the FIFO head
//   rsp_id    [IDW]        originating requester of rsp_data
//
// Modports:
//   master - the requesters and the response consumer (drives valid/data/ready)
//   slave  - the scheduler itself
// -----------------------------------------------------------------------------
interface serpent_pipe_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ*128-1:0] req_data;
  logic [NREQ-1:0]     req_ready;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [127:0]        rsp_data;
  logic [IDW-1:0]      rsp_id;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_data,
    input  rsp_id
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output rsp_valid,
    input  rsp_ready,
    output rsp_data,
    output rsp_id
  );

endinterface : serpent_pipe_sched_if

// File: rtl/serpent_pipe_sched.sv
// -----------------------------------------------------------------------------
// serpent_pipe_sched
//
// Shares one fully pipelined Serpent encryption core (one block per cycle,
// fixed latency PIPE_LAT) among NREQ requesters. A round-robin arbiter picks
// one requester per cycle, a shadow tag pipeline carries {valid, id} alongside
// the core, and completed blocks land in a response FIFO. Issue is limited by
// a credit counter (blocks issued but not yet popped), so the FIFO can never
// overflow and the core never needs to stall.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        serpent_pipe_sched_if.slave (req_* and rsp_* handshakes)
//   core_din   plaintext to the core (registered inside the core), zero when idle
//   core_dout  ciphertext from the core, PIPE_LAT cycles after core_din
//   inflight   blocks issued but not yet popped
//   busy       inflight != 0
//
// Optional build macro SERPENT_SCHED_STATS_EN adds:
//   stat_issued [NREQ*32]  per-requester count of accepted blocks
//   stat_stall  [32]       cycles with any req_valid and no credit
//
// Constraints: IDW >= clog2(NREQ), FIFO_DEPTH >= PIPE_LAT, PIPE_LAT >= 1.
// -----------------------------------------------------------------------------
module serpent_pipe_sched #(
  parameter  int NREQ       = 4,
  parameter  int IDW        = 2,
  parameter  int PIPE_LAT   = 33,
  parameter  int FIFO_DEPTH = 40,
  localparam int CNTW       = $clog2(FIFO_DEPTH + 1),
  localparam int PTRW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serpent_pipe_sched_if.slave  bus,
  output logic [127:0]         core_din,
  input  logic [127:0]         core_dout,
  output logic [CNTW-1:0]      inflight,
  output logic                 busy
`ifdef SERPENT_SCHED_STATS_EN
  ,
  output logic [NREQ*32-1:0]   stat_issued,
  output logic [31:0]          stat_stall
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IDW-1:0]               rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]              inflight_q, inflight_d;

  logic [PIPE_LAT-1:0]          tag_vld_q, tag_vld_d;
  logic [PIPE_LAT-1:0][IDW-1:0] tag_id_q, tag_id_d;

  logic [127:0]                 fifo_data_q [FIFO_DEPTH];
  logic [127:0]                 fifo_data_d [FIFO_DEPTH];
  logic [IDW-1:0]               fifo_id_q   [FIFO_DEPTH];
  logic [IDW-1:0]               fifo_id_d   [FIFO_DEPTH];
  logic [PTRW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]              fifo_cnt_q, fifo_cnt_d;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic           can_issue;
  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic           issue;
  logic           push;
  logic           pop;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(FIFO_DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // No new block is accepted while reset is held: the tag pipeline is frozen
  // clear, so an accepted block would silently vanish.
  assign can_issue = rst_n && (inflight_q < CNTW'(FIFO_DEPTH));
  assign issue     = can_issue && grant_found;
  assign push      = tag_vld_q[PIPE_LAT-1];
  assign pop       = (fifo_cnt_q != '0) && bus.rsp_ready;

  // Round-robin search starting just above the last granted index. Two
  // linear passes (above the pointer, then wrapping to the low indices)
  // avoid any modulo arithmetic on the index.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && bus.req_valid[i] && (i > int'(rr_ptr_q))) begin
        grant_found = 1'b1;
        grant_id    = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && bus.req_valid[i] && (i <= int'(rr_ptr_q))) begin
        grant_found = 1'b1;
        grant_id    = IDW'(i);
      end
    end
  end

  // Accept strobe and core input mux. Idle cycles feed zeros into the core;
  // the bubble is tracked as an invalid tag and never reaches the FIFO.
  always_comb begin
    bus.req_ready = '0;
    core_din      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (issue && (grant_id == IDW'(i))) begin
        bus.req_ready[i] = 1'b1;
        core_din         = bus.req_data[128*i +: 128];
      end
    end
  end

  // Pointer moves only on an actual issue so an unserved requester keeps
  // its place in the rotation.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = grant_id;
    end
  end

  // Credit counter: blocks issued but not yet popped.
  always_comb begin
    inflight_d = inflight_q;
    if (issue && !pop) begin
      inflight_d = inflight_q + CNTW'(1);
    end else if (!issue && pop) begin
      inflight_d = inflight_q - CNTW'(1);
    end
  end

  // Shadow tag pipeline: stage k is loaded on the same edge as core stage k,
  // so the last stage lines up with core_dout.
  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = issue;
    tag_id_d[0]  = grant_id;
    for (int k = 1; k < PIPE_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
  end

  // Response FIFO: circular buffer with an explicit occupancy count, which
  // makes same-cycle push/pop on a one-entry FIFO fall out naturally.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_id_d   = fifo_id_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;

    if (push) begin
      fifo_data_d[wr_ptr_q] = core_dout;
      fifo_id_d[wr_ptr_q]   = tag_id_q[PIPE_LAT-1];
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNTW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNTW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= IDW'(NREQ - 1);
      inflight_q <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      // NOTE: the FIFO storage is reset along with its pointers so that no
      // flop in the scheduler powers up or restarts holding stale ciphertext;
      // at this depth the storage is plain flops, not a RAM macro.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_id_q[i]   <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      inflight_q  <= inflight_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      fifo_data_q <= fifo_data_d;
      fifo_id_q   <= fifo_id_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.rsp_valid = (fifo_cnt_q != '0);
  assign bus.rsp_data  = fifo_data_q[rd_ptr_q];
  assign bus.rsp_id    = fifo_id_q[rd_ptr_q];
  assign inflight      = inflight_q;
  assign busy          = (inflight_q != '0);

  // The credit rule makes a push into a full FIFO unreachable.
  push_not_full_a : assert property (
    @(posedge clk) disable iff (!rst_n)
      !(push && (fifo_cnt_q == CNTW'(FIFO_DEPTH)))
  );

  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
`ifdef SERPENT_SCHED_STATS_EN
  logic [NREQ-1:0][31:0] stat_issued_q, stat_issued_d;
  logic [31:0]           stat_stall_q, stat_stall_d;

  // Free-running 32-bit counters; wrap-around is intended.
  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_stall_d  = stat_stall_q;
    if (issue) begin
      stat_issued_d[grant_id] = stat_issued_q[grant_id] + 32'd1;
    end
    if ((|bus.req_valid) && !can_issue) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule : serpent_pipe_sched

// File: tb/tb_serpent_pipe_sched.sv
// -----------------------------------------------------------------------------
// tb_serpent_pipe_sched
//
// Self-checking bench for serpent_pipe_sched. The core is modelled as a
// PIPE_LAT-stage delay line. A reference model keeps a queue of issued
// blocks with the cycle each must become visible, the round-robin rule as
// "first valid index after the last grant", and a credit count; every cycle
// the DUT's req_ready, rsp_valid, inflight and busy are compared against it,
// and every pop is compared against the queue head.
// Build with +define+SERPENT_SCHED_STATS_EN to include the statistics checks.
// -----------------------------------------------------------------------------
module tb_serpent_pipe_sched;

  localparam int NREQ       = 4;
  localparam int IDW        = 2;
  localparam int PIPE_LAT   = 33;
  localparam int FIFO_DEPTH = 40;
  localparam int CNTW       = $clog2(FIFO_DEPTH + 1);

  logic                clk = 1'b0;
  logic                rst_n;
  logic [127:0]        core_din;
  logic [127:0]        core_dout;
  logic [CNTW-1:0]     inflight;
  logic                busy;
`ifdef SERPENT_SCHED_STATS_EN
  logic [NREQ*32-1:0]  stat_issued;
  logic [31:0]         stat_stall;
`endif

  always #5 clk = ~clk;

  serpent_pipe_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  serpent_pipe_sched #(
    .NREQ       (NREQ),
    .IDW        (IDW),
    .PIPE_LAT   (PIPE_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .core_din   (core_din),
    .core_dout  (core_dout),
    .inflight   (inflight),
    .busy       (busy)
`ifdef SERPENT_SCHED_STATS_EN
    ,
    .stat_issued(stat_issued),
    .stat_stall (stat_stall)
`endif
  );

  // Identity core: plain delay line, no reset.
  logic [127:0] core_pipe [PIPE_LAT];
  always @(posedge clk) begin
    core_pipe[0] <= core_din;
    for (int i = 1; i < PIPE_LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_dout = core_pipe[PIPE_LAT-1];

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [IDW-1:0] id;
    logic [127:0]   data;
    int             due;
  } exp_t;

  exp_t            exp_q[$];
  int              m_ptr;
  int              m_inflight;
  int              m_issued [NREQ];
  int              m_stall;
  int              cyc;
  int              n_issues;
  int              n_pops;
  logic [NREQ-1:0] accepted;
  logic [NREQ-1:0] last_grant;
  logic            pop_now;
  logic            issue_now;

  task automatic model_clear();
    exp_q.delete();
    m_ptr      = NREQ - 1;
    m_inflight = 0;
    m_stall    = 0;
    accepted   = '0;
    for (int i = 0; i < NREQ; i++) m_issued[i] = 0;
  endtask

  // One clock cycle: compare at the falling edge, advance the model to match
  // the coming rising edge, return 1 time unit after that edge.
  task automatic cycle();
    logic [NREQ-1:0] exp_rdy;
    logic            exp_rv;
    int              g;
    exp_t            e;
    @(negedge clk);
    exp_rdy   = '0;
    g         = -1;
    accepted  = '0;
    pop_now   = 1'b0;
    issue_now = 1'b0;
    if (rst_n) begin
      if (m_inflight < FIFO_DEPTH) begin
        for (int k = 1; k <= NREQ; k++) begin
          int idx;
          idx = (m_ptr + k) % NREQ;
          if (g < 0 && bus.req_valid[idx]) g = idx;
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
      end else if (|bus.req_valid) begin
        m_stall++;
      end
    end
    exp_rv = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    check("req_ready", bus.req_ready, exp_rdy);
    check("rsp_valid", bus.rsp_valid, exp_rv);
    check("inflight",  inflight, m_inflight);
    check("busy",      busy, m_inflight != 0);
    last_grant = bus.req_ready;
    if (exp_rv && bus.rsp_ready) begin
      check("rsp_data", bus.rsp_data, exp_q[0].data);
      check("rsp_id",   bus.rsp_id,   exp_q[0].id);
      void'(exp_q.pop_front());
      m_inflight--;
      n_pops++;
      pop_now = 1'b1;
    end
    if (g >= 0) begin
      e.id   = IDW'(g);
      e.data = bus.req_data[128*g +: 128];
      e.due  = cyc + PIPE_LAT + 1;
      exp_q.push_back(e);
      m_ptr = g;
      m_inflight++;
      m_issued[g]++;
      n_issues++;
      accepted[g] = 1'b1;
      issue_now   = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic apply_reset(input int ncyc);
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_inflight",  inflight, '0);
    check("rst_busy",      busy, 1'b0);
    model_clear();
    repeat (ncyc) cycle();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Requesters hold a block until it is accepted, then maybe offer another.
  task automatic drive_random(input int vpct, input int rpct);
    for (int i = 0; i < NREQ; i++) begin
      if (!bus.req_valid[i] || accepted[i]) begin
        bus.req_valid[i]           = ($urandom_range(99) < vpct);
        bus.req_data[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    bus.rsp_ready = ($urandom_range(99) < rpct);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int t;
    int base;
    int fp;
    int fi;
    int seen;
    logic [NREQ-1:0] exp_g;

    cyc      = 0;
    n_issues = 0;
    n_pops   = 0;
    rst_n    = 1'b1;
    model_clear();

    // Reset with every requester asserting valid: nothing may be accepted.
    bus.req_valid = '1;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    apply_reset(3);
    bus.req_valid = '0;

    // --- Single block latency: requester 1 at cycle 5 ---
    repeat (5) cycle();
    bus.req_valid[1]          = 1'b1;
    bus.req_data[128 +: 128]  = 128'h00112233445566778899AABBCCDDEEFF;
    cycle();
    bus.req_valid[1] = 1'b0;
    t = 0;
    while (!bus.rsp_valid && t < 100) begin
      cycle();
      t++;
    end
    check("lat_first_valid_cycle", cyc, 39);
    check("lat_rsp_data", bus.rsp_data, 128'h00112233445566778899AABBCCDDEEFF);
    check("lat_rsp_id",   bus.rsp_id, 1);
    cycle();
    check("lat_inflight_zero", inflight, '0);

    // --- All requesters valid, data = own ID: strict rotation ---
    apply_reset(2);
    for (int i = 0; i < NREQ; i++) bus.req_data[128*i +: 128] = 128'(i);
    bus.req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      exp_g = '0;
      exp_g[k % NREQ] = 1'b1;
      check("rr_rotation", last_grant, exp_g);
    end
    repeat (60) cycle();
    bus.req_valid = '0;
    repeat (PIPE_LAT + 5) cycle();

    // --- Back-pressure: exactly FIFO_DEPTH issues, then no credit ---
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++)
      bus.req_data[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
    bus.req_valid = '1;
    base = n_issues;
    repeat (70) cycle();
    check("stall_issue_count", n_issues - base, FIFO_DEPTH);
    check("stall_ready_zero",  bus.req_ready, '0);
    bus.rsp_ready = 1'b1;
    base = n_pops;
    fp = -1;
    fi = -1;
    for (int k = 0; k < 50; k++) begin
      t = cyc;
      cycle();
      if (pop_now && fp < 0) fp = t;
      if (issue_now && fi < 0) fi = t;
    end
    check("resume_within_1", (fp >= 0) && (fi >= fp) && (fi - fp <= 1), 1'b1);
    check("stall_pops_40", (n_pops - base) >= FIFO_DEPTH, 1'b1);
    bus.req_valid = '0;
    repeat (FIFO_DEPTH + PIPE_LAT + 5) cycle();

    // --- Reset with 20 blocks in flight ---
    bus.req_valid = '1;
    base = n_issues;
    repeat (20) cycle();
    check("pre_rst_issues", n_issues - base, 20);
    check("pre_rst_inflight", inflight, 20);
    apply_reset(2);
    bus.req_valid = '0;
    seen = 0;
    repeat (40) begin
      cycle();
      if (bus.rsp_valid) seen++;
    end
    check("dropped_no_rsp", seen, 0);

    // --- Requester 3 alone, then requester 0 joins ---
    bus.req_valid    = '0;
    bus.req_valid[3] = 1'b1;
    cycle();
    check("solo_grant_3", last_grant, 4'b1000);
    bus.req_valid[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      exp_g = (k % 2 == 0) ? 4'b0001 : 4'b1000;
      check("join_alternate", last_grant, exp_g);
    end
    bus.req_valid = '0;
    repeat (PIPE_LAT + 5) cycle();

`ifdef SERPENT_SCHED_STATS_EN
    // --- Statistics over the same two-requester pattern ---
    apply_reset(2);
    bus.rsp_ready    = 1'b1;
    bus.req_valid    = '0;
    bus.req_valid[0] = 1'b1;
    bus.req_valid[3] = 1'b1;
    base = n_issues;
    repeat (100) cycle();
    seen = 0;
    for (int i = 0; i < NREQ; i++) seen += int'(stat_issued[32*i +: 32]);
    check("stat_issued_sum", seen, n_issues - base);
    check("stat_stall_zero", stat_stall, 0);
    bus.req_valid = '0;
`endif

    // --- Randomised traffic: light then heavy back-pressure ---
    for (int k = 0; k < 400; k++) begin
      drive_random(60, 80);
      cycle();
    end
    for (int k = 0; k < 400; k++) begin
      drive_random(70, 15);
      cycle();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (FIFO_DEPTH + PIPE_LAT + 10) cycle();
    check("drain_rsp_valid", bus.rsp_valid, 1'b0);
    check("drain_inflight",  inflight, '0);
    check("drain_model_empty", exp_q.size(), 0);

`ifdef SERPENT_SCHED_STATS_EN
    for (int i = 0; i < NREQ; i++)
      check("stat_issued_req", stat_issued[32*i +: 32], m_issued[i]);
    check("stat_stall_total", stat_stall, m_stall);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serpent_pipe_sched

// File: doc/serpent_pipe_sched.md
Name: serpent_pipe_sched

Overview:
- Shares one fully pipelined Serpent encryption core (one block accepted per cycle, fixed latency) among NREQ requesters.
- Round-robin arbitration with a valid/ready handshake on each requester.
- A shadow tag pipeline tracks each block's requester ID alongside the core; results land in a response FIFO with a single valid/ready output.
- Credit-based issue guarantees the FIFO never overflows, so the core needs no stall.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must be at least clog2(NREQ).
- PIPE_LAT, 33, core latency: cycles from core_din being sampled to the matching core_dout.
- FIFO_DEPTH, 40, response FIFO entries; must be at least PIPE_LAT; power of two not required.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester block valid.
- req_data  in  NREQ*128  per-requester plaintext; requester i uses bits [128*i+127 : 128*i].
- req_ready  out  NREQ  one-hot (or zero) accept strobe.
- core_din  out  128  plaintext to the core; registered by the core.
- core_dout  in  128  ciphertext from the core.
- rsp_valid  out  1  response FIFO not empty.
- rsp_ready  in  1  consumer accept.
- rsp_data  out  128  ciphertext at the FIFO head.
- rsp_id  out  IDW  originating requester of rsp_data.
- inflight  out  clog2(FIFO_DEPTH+1)  blocks issued but not yet popped.
- busy  out  1  inflight != 0.

Behaviour:
- Reset is asynchronous on rst_n low and applies to every sequential element. Reset values:
  - tag pipeline cleared;
  - FIFO empty, rsp_valid=0;
  - inflight=0, busy=0;
  - round-robin pointer=NREQ-1, so requester 0 has first priority;
  - req_ready=0.
- Core datapath carries no reset. On reset mid-operation, blocks already in the core are discarded, because their tags are cleared. No response may appear for them after reset release.
- Credit:
  - can_issue = (inflight < FIFO_DEPTH).
  - inflight increments on issue, decrements on pop, and is unchanged when both occur in the same cycle.
- Arbitration, combinational within the cycle:
  - If can_issue, grant the first i with req_valid[i]=1, searching from pointer+1 and wrapping modulo NREQ.
  - req_ready[i]=1 only for the granted requester.
  - Issue occurs when a grant exists, that requester's req_valid=1 and its req_ready=1.
  - The pointer updates to the granted index only on issue.
  - req_ready may depend on req_valid; requesters must not make valid depend on ready.
- Core drive:
  - core_din = granted req_data when issuing, else 128'h0.
  - Idle cycles still advance the core, carrying bubbles.
- Tag pipeline: a shift register PIPE_LAT deep of {valid, id}.
  - Stage 0 loads {issue, granted id}.
  - Stage PIPE_LAT-1 is aligned with core_dout in the same cycle.
  - When the last-stage valid=1, {id, core_dout} is pushed into the FIFO.
- Response FIFO:
  - Circular buffer of FIFO_DEPTH entries; read and write pointers wrap at FIFO_DEPTH-1 back to 0.
  - Pop occurs when rsp_valid and rsp_ready are both high.
  - rsp_data and rsp_id are driven from the head entry, combinational from storage. They are stable while rsp_valid=1 and rsp_ready=0.
  - Push and pop in the same cycle are both permitted, including when the FIFO holds one entry.
  - A push into a full FIFO is impossible by the credit rule; simulation asserts if it occurs.
- Ordering:
  - Responses leave in global issue order.
  - Per-requester order is preserved.
  - Throughput is 1 block/cycle sustained while rsp_ready=1.
- Latency: a block issued in cycle T is pushed at edge T+PIPE_LAT and visible on rsp_valid in cycle T+PIPE_LAT+1 if the FIFO was empty.
- Stall: with rsp_ready=0, at most FIFO_DEPTH blocks are accepted, then every req_ready=0 until a pop occurs.

Optional Feature:
- Macro: SERPENT_SCHED_STATS_EN.
- When defined, extra output ports are added:
  - stat_issued [NREQ*32]: per-requester count of accepted blocks.
  - stat_stall [32]: cycles with any req_valid=1 and can_issue=0.
- Counters wrap at 2^32, reset to 0 by rst_n, and use 32-bit saturation-free arithmetic.
- When undefined, these ports and counters do not exist. Functional behaviour is otherwise identical.

Test Plan:
- Bench core model is a PIPE_LAT-stage delay line, i.e. identity.
  - Stimulus: requester 1 sends 128'h0011...EEFF at cycle 5, rsp_ready=1.
  - Required response: rsp_valid first high in cycle 39 with rsp_data=0011...EEFF, rsp_id=1; inflight returns to 0 after the pop.
- All 4 requesters hold valid continuously, each sending a data word equal to its own ID.
  - Required response: grants cycle 0,1,2,3,0,...; rsp_id sequence identical; one response per cycle after the initial fill.
- rsp_ready=0 while all requesters stay valid.
  - Required response: exactly 40 issues, then req_ready=0.
  - After raising rsp_ready: 40 responses in issue order, and issue resumes within 1 cycle of the first pop.
- rst_n pulsed low for 2 cycles while 20 blocks are in flight.
  - Required response: immediate rsp_valid=0 and inflight=0; no response for the 20 dropped blocks during the next 40 cycles.
- Only requester 3 valid, then requester 0 joins.
  - Required response: pointer=3 after the first grant, so requester 0 wins the next cycle; requester 3 is not granted twice in a row while requester 0 waits.
- With SERPENT_SCHED_STATS_EN defined, run the previous scenario for 100 cycles.
  - Required response: stat_issued sums to the total issues; stat_stall=0 while rsp_ready=1.
